// File: rtl/robot_pkg.sv
// robot_pkg: shared orientation encoding, map defaults, widths and tracker state type.
package robot_pkg;
  localparam logic [1:0] NORTH = 2'b00;
  localparam logic [1:0] SOUTH = 2'b01;
  localparam logic [1:0] EAST  = 2'b10;
  localparam logic [1:0] WEST  = 2'b11;
  localparam int ROWS_DEF = 10;
  localparam int COLS_DEF = 20;
  localparam int CW = 6;
  localparam int MW = 9;
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;
  function automatic logic [1:0] rot_left(input logic [1:0] d);
    return d == NORTH ? WEST : d == WEST ? SOUTH : d == SOUTH ? EAST : NORTH;
  endfunction
endpackage

// File: rtl/robot_pose_tracker_if.sv
// robot_pose_tracker_if: run control, robot commands and pose/status outputs of the tracker.
interface robot_pose_tracker_if;
  import robot_pkg::*;
  logic          start;
  logic [CW-1:0] init_row;
  logic [CW-1:0] init_col;
  logic [1:0]    init_dir;
  logic [MW-1:0] max_moves;
  logic          front;
  logic          turn;
  logic          remove;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [1:0]    dir;
  logic [MW-1:0] moves;
  logic          busy;
  logic          done;
  logic          anomaly;
  logic          illegal_cmd;
  logic          removed;
  logic [CW-1:0] removed_row;
  logic [CW-1:0] removed_col;
  logic [7:0]    trash_count;
  modport master (
    output start, init_row, init_col, init_dir, max_moves, front, turn, remove,
    input  row, col, dir, moves, busy, done, anomaly, illegal_cmd,
           removed, removed_row, removed_col, trash_count
  );
  modport slave (
    input  start, init_row, init_col, init_dir, max_moves, front, turn, remove,
    output row, col, dir, moves, busy, done, anomaly, illegal_cmd,
           removed, removed_row, removed_col, trash_count
  );
endinterface

// File: rtl/robot_trash_counter.sv
// robot_trash_counter: counts consecutive remove cycles, pulses on each completed removal.
module robot_trash_counter import robot_pkg::*; #(
  parameter int REMOVE_CYCLES = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic          remove,
  input  logic [CW-1:0] cell_row,
  input  logic [CW-1:0] cell_col,
  output logic          removed,
  output logic [CW-1:0] removed_row,
  output logic [CW-1:0] removed_col,
  output logic [7:0]    trash_count
);
  localparam int NW = $clog2(REMOVE_CYCLES + 1);
  logic [NW-1:0] cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      removed <= 1'b0;
      removed_row <= '0;
      removed_col <= '0;
      trash_count <= '0;
    end else if (clear) begin
      cnt <= '0;
      removed <= 1'b0;
      trash_count <= '0;
    end else if (en && remove && cnt == NW'(REMOVE_CYCLES - 1)) begin
      cnt <= '0;
      removed <= 1'b1;
      removed_row <= cell_row;
      removed_col <= cell_col;
      trash_count <= trash_count == 8'hff ? trash_count : trash_count + 8'd1;
    end else begin
      cnt <= en && remove ? cnt + NW'(1) : '0;
      removed <= 1'b0;
    end
  end
endmodule

// File: rtl/robot_pose_tracker.sv
// robot_pose_tracker: architectural pose, step count and fault flags of the robot controller.
// Define ROBOT_POSE_TRACKER_TRASH_EN to build the trash-removal counter and its outputs.
module robot_pose_tracker import robot_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int REMOVE_CYCLES = 3
) (
  input logic clock,
  input logic reset,
  robot_pose_tracker_if.slave p
);
  localparam logic [CW-1:0] ROW_MAX = CW'(ROWS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS);
  state_t state, nxt;
  logic [CW-1:0] tgt_row, tgt_col;
  logic [MW-1:0] max_r;
  logic oom, last, run;
  // cell in front of the robot; 6-bit wrap on row/col 0 lands out of range
  assign tgt_row = p.dir == NORTH ? p.row - CW'(1) : p.dir == SOUTH ? p.row + CW'(1) : p.row;
  assign tgt_col = p.dir == WEST ? p.col - CW'(1) : p.dir == EAST ? p.col + CW'(1) : p.col;
  assign oom = tgt_row == '0 || tgt_row > ROW_MAX || tgt_col == '0 || tgt_col > COL_MAX;
  assign last = p.moves + MW'(1) == max_r;
  assign run = state == RUN && !p.start;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (p.start) nxt = p.max_moves == '0 ? DONE : RUN;
    else if (state == RUN) nxt = p.front && oom ? FAULT : last ? DONE : RUN;
  end
  always_comb begin
    p.busy = state == RUN;
    p.done = state == DONE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p.row <= CW'(1);
      p.col <= CW'(1);
      p.dir <= NORTH;
      p.moves <= '0;
      p.anomaly <= 1'b0;
      p.illegal_cmd <= 1'b0;
      max_r <= '0;
    end else if (p.start) begin
      p.row <= p.init_row;
      p.col <= p.init_col;
      p.dir <= p.init_dir;
      p.moves <= '0;
      p.anomaly <= 1'b0;
      p.illegal_cmd <= 1'b0;
      max_r <= p.max_moves;
    end else if (state == RUN) begin
      p.moves <= p.moves + MW'(1);
      p.illegal_cmd <= p.illegal_cmd | (p.front & p.turn);
      if (p.front) begin
        if (oom) p.anomaly <= 1'b1;
        else begin
          p.row <= tgt_row;
          p.col <= tgt_col;
        end
      end else if (p.turn) p.dir <= rot_left(p.dir);
    end
  end
`ifdef ROBOT_POSE_TRACKER_TRASH_EN
  robot_trash_counter #(.REMOVE_CYCLES(REMOVE_CYCLES)) u_trash (
    .clock(clock),
    .reset(reset),
    .clear(p.start),
    .en(run),
    .remove(p.remove),
    .cell_row(tgt_row),
    .cell_col(tgt_col),
    .removed(p.removed),
    .removed_row(p.removed_row),
    .removed_col(p.removed_col),
    .trash_count(p.trash_count)
  );
`else
  assign p.removed = 1'b0;
  assign p.removed_row = '0;
  assign p.removed_col = '0;
  assign p.trash_count = '0;
`endif
endmodule

// File: tb/tb_robot_pose_tracker.sv
// tb_robot_pose_tracker: directed vectors with hand-computed pose, flag and removal expectations.
module tb_robot_pose_tracker;
  logic clock, reset;
  int checks = 0, errors = 0;
`ifdef ROBOT_POSE_TRACKER_TRASH_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif
  robot_pose_tracker_if bus();
  robot_pose_tracker dut (.clock(clock), .reset(reset), .p(bus.slave));
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic load(input int r, input int c, input int d, input int m);
    bus.init_row = 6'(r);
    bus.init_col = 6'(c);
    bus.init_dir = 2'(d);
    bus.max_moves = 9'(m);
    bus.start = 1;
    step;
    bus.start = 0;
  endtask
  task automatic pose(input string tag, input int r, input int c, input int d);
    check({tag, ".row"}, 32'(bus.row), r);
    check({tag, ".col"}, 32'(bus.col), c);
    check({tag, ".dir"}, 32'(bus.dir), d);
  endtask
  initial begin
    reset = 1;
    bus.start = 0; bus.front = 0; bus.turn = 0; bus.remove = 0;
    bus.init_row = 0; bus.init_col = 0; bus.init_dir = 0; bus.max_moves = 0;
    #12;
    pose("rst", 1, 1, 0);
    check("rst.moves", 32'(bus.moves), 0);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.anomaly", 32'(bus.anomaly), 0);
    check("rst.trash", 32'(bus.trash_count), 0);
    reset = 0;
    // basic moves: (5,5,N), 3 fronts then an idle step
    load(5, 5, 0, 4);
    check("mv.busy", 32'(bus.busy), 1);
    pose("mv0", 5, 5, 0);
    bus.front = 1;
    step; pose("mv1", 4, 5, 0); check("mv1.moves", 32'(bus.moves), 1);
    step; check("mv2.row", 32'(bus.row), 3);
    step; check("mv3.row", 32'(bus.row), 2); check("mv3.busy", 32'(bus.busy), 1);
    bus.front = 0;
    step; pose("mv4", 2, 5, 0);
    check("mv4.moves", 32'(bus.moves), 4);
    check("mv4.done", 32'(bus.done), 1);
    check("mv4.busy", 32'(bus.busy), 0);
    // left turns from E: N, W, S, E
    load(2, 2, 2, 10);
    bus.turn = 1;
    step; check("t1.dir", 32'(bus.dir), 0);
    step; check("t2.dir", 32'(bus.dir), 3);
    step; check("t3.dir", 32'(bus.dir), 1);
    step; pose("t4", 2, 2, 2);
    bus.turn = 0;
    // edge exit at the top row
    load(1, 20, 0, 5);
    bus.front = 1;
    step;
    bus.front = 0;
    check("oom.anomaly", 32'(bus.anomaly), 1);
    check("oom.row", 32'(bus.row), 1);
    check("oom.moves", 32'(bus.moves), 1);
    check("oom.busy", 32'(bus.busy), 0);
    check("oom.done", 32'(bus.done), 0);
    step; check("oom.hold", 32'(bus.moves), 1);
    load(3, 3, 3, 20);
    check("restart.anomaly", 32'(bus.anomaly), 0);
    check("restart.busy", 32'(bus.busy), 1);
    // removal facing W from (3,3): cleared cell is (3,2)
    bus.remove = 1;
    step; check("rm1.removed", 32'(bus.removed), 0);
    step; check("rm2.removed", 32'(bus.removed), 0);
    step;
    check("rm3.removed", 32'(bus.removed), TE ? 1 : 0);
    check("rm3.row", 32'(bus.removed_row), TE ? 3 : 0);
    check("rm3.col", 32'(bus.removed_col), TE ? 2 : 0);
    check("rm3.trash", 32'(bus.trash_count), TE ? 1 : 0);
    bus.remove = 0;
    step; check("rm4.removed", 32'(bus.removed), 0);
    bus.remove = 1;
    step; step; check("rm6.removed", 32'(bus.removed), 0);
    bus.remove = 0;
    step; check("rm7.removed", 32'(bus.removed), 0);
    bus.remove = 1;
    step; check("rm8.removed", 32'(bus.removed), 0);
    step; check("rm9.removed", 32'(bus.removed), 0);
    bus.remove = 0;
    check("rm9.trash", 32'(bus.trash_count), TE ? 1 : 0);
    check("rm9.moves", 32'(bus.moves), 9);
    // front and turn together
    load(4, 4, 1, 10);
    bus.front = 1; bus.turn = 1;
    step;
    bus.front = 0; bus.turn = 0;
    pose("cf", 5, 4, 1);
    check("cf.illegal", 32'(bus.illegal_cmd), 1);
    // asynchronous reset mid-run
    #2 reset = 1;
    #1;
    pose("ar", 1, 1, 0);
    check("ar.moves", 32'(bus.moves), 0);
    check("ar.busy", 32'(bus.busy), 0);
    check("ar.illegal", 32'(bus.illegal_cmd), 0);
    #3 reset = 0;
    // zero-length run goes straight to DONE
    load(7, 9, 2, 0);
    pose("z", 7, 9, 2);
    check("z.done", 32'(bus.done), 1);
    check("z.busy", 32'(bus.busy), 0);
    check("z.moves", 32'(bus.moves), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
